// File: rtl/synth_div_pkg.sv
// synth_div_pkg: shared constants and channel-index width helper for the tone divider bank
package synth_div_pkg;
  localparam int DEF_CNT_W = 21;
  localparam int DEF_DIV = 50;
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tone_divider_bank_div_channel.sv
// div_channel: one divider (clk, rst async low, ce, sync, load/load_div shadow write -> wave, tick, pending); new divisors apply only on a half-period boundary
module div_channel
  import synth_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             wave,
  output logic             tick,
  output logic             pending
);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d;
  logic wave_q, wave_d, tick_q, tick_d, pend_q, pend_d;
  logic at_end;
  assign at_end = cnt_q == div_q - CNT_W'(1);
  always_comb begin
    cnt_d = cnt_q;
    wave_d = wave_q;
    tick_d = 1'b0;
    div_d = div_q;
    shadow_d = load ? load_div : shadow_q;
    pend_d = pend_q | load;
    if (sync) begin
      cnt_d = '0;
      wave_d = 1'b0;
    end else if (div_q == '0) begin
      cnt_d = '0;
      wave_d = 1'b0;
      div_d = pend_q ? shadow_q : div_q;
      pend_d = pend_d & ~pend_q;
    end else if (ce) begin
      cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
      tick_d = at_end;
      wave_d = !at_end ? wave_q : (pend_q && shadow_q == '0) ? 1'b0 : ~wave_q;
      div_d = (at_end && pend_q) ? shadow_q : div_q;
      pend_d = (at_end && pend_q) ? 1'b0 : pend_d;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      wave_q <= 1'b0;
      tick_q <= 1'b0;
      div_q <= CNT_W'(DEFAULT_DIV);
      shadow_q <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wave_q <= wave_d;
      tick_q <= tick_d;
      div_q <= div_d;
      shadow_q <= shadow_d;
      pend_q <= pend_d;
    end
  end
  assign wave = wave_q;
  assign tick = tick_q;
  assign pending = pend_q;
endmodule

// File: rtl/tone_divider_bank.sv
// tone_divider_bank: CHANNELS glitch-free tone dividers (clk, rst async low, ce, sync, cfg_valid/cfg_ready/cfg_ch/cfg_div write port -> wave, tick, pending)
module tone_divider_bank
  import synth_div_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV,
  localparam int CH_W = ch_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                sync,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic [CHANNELS-1:0] wave,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);
  logic [2**CH_W-1:0] pend_x;
  logic [CHANNELS-1:0] load;
  always_comb begin
    pend_x = '0;
    pend_x[CHANNELS-1:0] = pending;
  end
  assign cfg_ready = ~pend_x[cfg_ch];
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign load[g] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));
    div_channel #(
      .CNT_W(CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .ce(ce),
      .sync(sync),
      .load(load[g]),
      .load_div(cfg_div),
      .wave(wave[g]),
      .tick(tick[g]),
      .pending(pending[g])
    );
  end
endmodule

// File: tb/tb_tone_divider_bank.sv
// tb_tone_divider_bank: scoreboard bench for the tone divider bank
module tb_tone_divider_bank;
  localparam int CH = 4;
  localparam int CW = 21;
  typedef struct {
    int cyc;
    int ch;
    bit w;
  } ev_t;
  logic clk, rst, ce, sync, cfg_valid, cfg_ready;
  logic [1:0] cfg_ch;
  logic [CW-1:0] cfg_div;
  logic [CH-1:0] wave, tick, pending;
  int cyc, n_tests, n_fail;
  bit alt;
  ev_t q[$];

  tone_divider_bank #(.CHANNELS(CH), .CNT_W(CW), .DEFAULT_DIV(50)) dut (
    .clk(clk), .rst(rst), .ce(ce), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .wave(wave), .tick(tick), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic void push(int c, int ch, bit w);
    int i = 0;
    while (i < q.size() && (q[i].cyc < c || (q[i].cyc == c && q[i].ch < ch))) i++;
    q.insert(i, '{c, ch, w});
  endfunction

  function automatic void push_run(int ch, int first, int per, int n, bit w0);
    for (int i = 0; i < n; i++) push(first + i * per, ch, w0 ^ i[0]);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(int c);
    int g = 0;
    while (cyc < c && g < 1000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (cyc < c) begin
      $display("FAIL wait_cyc timeout: got cyc %0d expected %0d", cyc, c);
      n_fail++;
    end
  endtask

  task automatic wr(int ch, int d, bit exp_rdy);
    cfg_valid = 1'b1;
    cfg_ch = 2'(ch);
    cfg_div = CW'(d);
    chk("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
    wait_cyc(cyc + 1);
    cfg_valid = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    logic [CH-1:0] em, ew;
    ev_t e;
    if (rst) begin
      em = '0;
      ew = '0;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL missing_tick ch%0d: got none at cyc %0d expected tick wave %0d", e.ch, e.cyc, e.w);
        end else begin
          em[e.ch] = 1'b1;
          ew[e.ch] = e.w;
        end
      end
      if (em != '0 || tick != '0) begin
        n_tests++;
        if (tick != em || (wave & em) != (ew & em)) begin
          n_fail++;
          $display("FAIL tick_sb at cyc %0d: got tick %b wave %b expected tick %b wave %b (masked)",
                   cyc, tick, wave & em, em, ew & em);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ce = 1'b0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; alt = 1'b0;
    n_tests = 0; n_fail = 0;
    fork
      forever begin
        @(posedge clk);
        #2;
        if (alt) ce = cyc[0];
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wave", 32'(wave), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    push_run(0, 50, 50, 4, 1'b1);
    push(50, 1, 1'b1); push(60, 1, 1'b0); push(70, 1, 1'b1);
    push_run(1, 80, 4, 31, 1'b0);
    push(208, 1, 1'b1); push(216, 1, 1'b0); push(224, 1, 1'b1); push(236, 1, 1'b1);
    push(50, 2, 1'b1); push(100, 2, 1'b0); push(150, 2, 1'b0);
    push_run(2, 166, 5, 7, 1'b1);
    push(210, 2, 1'b1); push(220, 2, 1'b0); push(238, 2, 1'b1);
    push_run(3, 50, 50, 4, 1'b1);
    push_run(3, 206, 6, 4, 1'b1);
    push(234, 3, 1'b1); push(240, 3, 1'b0);
    rst = 1'b1;
    ce = 1'b1;
    wait_cyc(19);
    wr(1, 10, 1'b1);
    chk("pend_set", 32'(pending), 32'b0010);
    wr(1, 7, 1'b0);
    chk("pend_hold", 32'(pending), 32'b0010);
    wait_cyc(50);
    chk("pend_applied", 32'(pending), 0);
    chk("wave_50", 32'(wave), 32'b1111);
    wait_cyc(75);
    wr(1, 4, 1'b1);
    chk("retry_pend", 32'(pending), 32'b0010);
    wait_cyc(109);
    wr(2, 0, 1'b1);
    wait_cyc(150);
    chk("mute_wave", 32'(wave), 32'b1011);
    chk("mute_pend", 32'(pending), 0);
    wait_cyc(159);
    wr(2, 5, 1'b1);
    chk("idle_pend", 32'(pending), 32'b0100);
    wait_cyc(161);
    chk("idle_apply", 32'(pending), 0);
    wait_cyc(180);
    wr(3, 3, 1'b1);
    wait_cyc(200);
    sync = 1'b1;
    alt = 1'b1;
    wait_cyc(201);
    sync = 1'b0;
    chk("sync_wave", 32'(wave), 0);
    wait_cyc(224);
    wr(0, 2, 1'b1);
    wait_cyc(226);
    chk("pend_ch0", 32'(pending), 32'b0001);
    wait_cyc(227);
    sync = 1'b1;
    wait_cyc(228);
    sync = 1'b0;
    chk("sync2_wave", 32'(wave), 0);
    chk("sync2_pend", 32'(pending), 32'b0001);
    wait_cyc(240);
    chk("pre_rst_wave", 32'(wave), 32'b0110);
    wait_cyc(241);
    alt = 1'b0;
    ce = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_wave", 32'(wave), 0);
    chk("arst_tick", 32'(tick), 0);
    chk("arst_pend", 32'(pending), 0);
    chk("sb_drain1", q.size(), 0);
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) push_run(c, 50, 50, 2, 1'b1);
    rst = 1'b1;
    ce = 1'b1;
    wait_cyc(1);
    chk("post_rst_pend", 32'(pending), 0);
    wait_cyc(101);
    chk("sb_drain2", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tone_divider_bank.md
Name: tone_divider_bank

Overview:
Bank of CHANNELS independent programmable clock dividers generating square-wave tone clocks for the synthesizer voices. Each channel holds an active divisor plus a shadow register, so a new pitch only takes effect on a half-period boundary (glitch-free). Divisors are loaded at runtime through a valid/ready config port. Counting is gated by a shared clock-enable from the system prescaler.

Parameters:
CHANNELS, 4, number of divider channels (1..16)
CNT_W, 21, width of counters and divisors
DEFAULT_DIV, 50, active divisor of every channel after reset (half-period in ce cycles)
CH_W, max(1, clog2(CHANNELS)), width of channel index (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ce  in  1  count enable; counters advance only when 1
sync  in  1  phase restart pulse for all channels
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when valid&ready
cfg_ch  in  CH_W  target channel
cfg_div  in  CNT_W  new half-period divisor (0 = mute)
wave  out  CHANNELS  per-channel square wave
tick  out  CHANNELS  per-channel one-clk pulse on every wave toggle
pending  out  CHANNELS  per-channel shadow-register-full flag

Behaviour:
- Reset (rst=0, async): cnt=0, wave=0, tick=0, div=DEFAULT_DIV, shadow=0, pending=0 on all channels. Reset mid-operation aborts immediately; pending loads are discarded.
- All outputs are registered except cfg_ready.
- cfg_ready = !pending[cfg_ch] (combinational). An out-of-range cfg_ch (>= CHANNELS) gives cfg_ready=1, and the write is dropped.
- Accepted write (cfg_valid & cfg_ready): shadow[ch] <= cfg_div, pending[ch] <= 1 on the next edge.
- Per channel, with div != 0 and ce = 1:
  - If cnt == div-1: cnt <= 0, wave toggles, tick <= 1 for one clk. If pending, div <= shadow and pending <= 0 in the same edge.
  - Otherwise cnt <= cnt+1.
- Per channel, with ce = 0: cnt, wave and div hold, and tick <= 0.
- Wave period = 2*div ce-cycles; div=1 toggles on every ce.
- Idle channel (div == 0): wave = 0 and cnt = 0.
  - If pending, apply it on the next clk regardless of ce: div <= shadow, pending <= 0, cnt <= 0.
  - First toggle then occurs after shadow ce-cycles.
- Mute: a pending 0 is applied at the boundary. On that edge, wave is forced to 0 instead of toggling, tick <= 1, cnt <= 0.
- sync=1 (all channels, overrides counting in that cycle): cnt <= 0, wave <= 0, tick <= 0. div, shadow and pending are untouched, so a pending load stays pending until the next boundary. A cfg write in the same cycle is accepted normally.
- Simultaneous boundary-apply and a new write on the same channel: cfg_ready is 0 (pending is still 1 that cycle), so the write is not accepted; the master retries next cycle.
- Counter arithmetic is CNT_W bits unsigned. If div is reduced below the current cnt, it cannot apply mid-period: shadow only applies at the boundary, so no wrap-around hazard.

Decomposition:
- Package synth_div_pkg holds:
  - clog2-based CH_W helper function
  - CNT_W default constant
  - DEFAULT_DIV constant
- Natural sub-module div_channel: one counter, div, shadow, pending, wave and tick.
  - Ports: clk, rst, ce, sync, load, load_div, wave, tick, pending.
  - Top level generates CHANNELS instances, decodes cfg_ch into per-channel load, and muxes pending for cfg_ready.

Test Plan:
- Reset, then ce=1 constant, defaults -> all wave toggle every 50 clks (first rise at clk 50), tick high exactly at each toggle, pending=0.
- Write ch1 div=10 at clk 20 -> pending[1]=1; first ch1 toggle still at clk 50; subsequent toggles every 10 clks; pending[1]=0 after clk 50.
- Second write to ch1 while pending[1]=1 -> cfg_ready=0, shadow holds first value; retry after apply -> accepted.
- Write ch2 div=0 -> wave[2] forced 0 at next boundary and stays 0. Then write div=5 -> applied next clk, first rise 5 ce-cycles later.
- ce toggled 1/0 alternately with div=3 -> wave period 12 clks. sync pulse mid-period -> all cnt/wave reset, pending preserved.
- Assert rst low for 1 clk mid-period with a pending load -> outputs 0 immediately, div back to 50, pending cleared.
